// File: rtl/sync_debouncer.sv
// sync_debouncer: brings asynchronous, bouncy inputs into the clk domain and
// qualifies each bit independently before it reaches the edge detector.
// A level change propagates to `signal` only after it has been seen at the
// synchronizer output for STABLE_CYCLES consecutive samples.
// Optional build macro: DEBOUNCE_GLITCH_CNT_EN adds an 8-bit saturating
// count of rejected glitches on port `glitch_cnt`.
//
// Per-bit filter states:
//   state      | meaning
//   ST_STABLE  | signal matches sync_out, no change under qualification
//   ST_PENDING | sync_out differs from signal, counting matching samples
module sync_debouncer #(
   parameter int               WIDTH         = 1,
   parameter int               SYNC_STAGES   = 2,
   parameter int               STABLE_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] signal,
   output logic [WIDTH-1:0] busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [7:0]       glitch_cnt
`endif
);

   localparam int              CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W:0]  CNT_TC = (CNT_W + 1)'(STABLE_CYCLES);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] w_sync_out;

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [WIDTH-1:0] w_reject;
   logic [7:0]       r_glitch_cnt;
`endif

   // Synchronizer chain: plain shift register, nothing between stages.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync[s] <= RESET_VAL;
         end
      end else begin
         r_sync[0] <= async_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
         end
      end
   end

   assign w_sync_out = r_sync[SYNC_STAGES-1];

   genvar g;
   for (g = 0; g < WIDTH; g++) begin : g_bit
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic [CNT_W:0]   w_cnt_inc;
      logic             r_signal;
      logic             w_signal_nxt;
      logic             r_busy;
      logic             w_mismatch;

      assign w_mismatch = (w_sync_out[g] != r_signal);
      // One bit wider than the counter so the terminal compare cannot wrap.
      assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

      // Filter state, count and output level registers.
      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            r_state  <= ST_STABLE;
            r_cnt    <= '0;
            r_signal <= RESET_VAL[g];
            r_busy   <= 1'b0;
         end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_signal <= w_signal_nxt;
            r_busy   <= (w_state_nxt == ST_PENDING);
         end
      end

      // Next-state and qualification logic for one bit.
      always_comb begin
         w_state_nxt  = r_state;
         w_cnt_nxt    = r_cnt;
         w_signal_nxt = r_signal;
         case (r_state)
            ST_STABLE: begin
               w_cnt_nxt = '0;
               if (w_mismatch) begin
                  if (STABLE_CYCLES == 1) begin
                     w_signal_nxt = w_sync_out[g];
                  end else begin
                     w_state_nxt = ST_PENDING;
                     w_cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            ST_PENDING: begin
               if (!w_mismatch) begin
                  w_state_nxt = ST_STABLE;
                  w_cnt_nxt   = '0;
               end else if (w_cnt_inc == CNT_TC) begin
                  w_signal_nxt = w_sync_out[g];
                  w_state_nxt  = ST_STABLE;
                  w_cnt_nxt    = '0;
               end else begin
                  w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
               end
            end
            default: begin
               w_state_nxt = ST_STABLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end

      assign signal[g] = r_signal;
      assign busy[g]   = r_busy;

`ifdef DEBOUNCE_GLITCH_CNT_EN
      assign w_reject[g] = (r_state == ST_PENDING) && !w_mismatch;
`endif
   end

`ifdef DEBOUNCE_GLITCH_CNT_EN
   // Count cycles with at least one rejected glitch; saturates at 255.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_glitch_cnt <= 8'd0;
      end else if ((|w_reject) && (r_glitch_cnt != 8'hFF)) begin
         r_glitch_cnt <= r_glitch_cnt + 8'd1;
      end
   end

   assign glitch_cnt = r_glitch_cnt;
`else
   // Without glitch statistics, rejected changes leave no trace.
`endif

endmodule

// File: tb/tb_sync_debouncer.sv
// Directed bench for sync_debouncer: a 4-bit default-timing instance and a
// 1-bit instance with SYNC_STAGES=3, STABLE_CYCLES=1.
module tb_sync_debouncer;

   logic       clk;
   logic       rst_n;
   logic [3:0] a_in;
   logic [3:0] a_sig;
   logic [3:0] a_busy;
   logic       b_in;
   logic       b_sig;
   logic       b_busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] a_gcnt;
   logic [7:0] b_gcnt;
`endif

   int total = 0;
   int bad   = 0;

   sync_debouncer #(.WIDTH(4)) dut_a (
      .clk      (clk),
      .n_rst    (rst_n),
      .async_in (a_in),
      .signal   (a_sig),
      .busy     (a_busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt (a_gcnt)
`endif
   );

   sync_debouncer #(.WIDTH(1), .SYNC_STAGES(3), .STABLE_CYCLES(1)) dut_b (
      .clk      (clk),
      .n_rst    (rst_n),
      .async_in (b_in),
      .signal   (b_sig),
      .busy     (b_busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt (b_gcnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset both instances with the given input levels; returns with the
   // next posedge being edge 0 after release.
   task automatic apply_reset(input logic [3:0] a, input logic b);
      a_in  = a;
      b_in  = b;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_in  = 4'hF;
      b_in  = 1'b1;
      #3;
      total++;
      if (a_sig !== 4'h0) begin bad++; $display("FAIL reset_sig_a got=%h exp=0", a_sig); end
      total++;
      if (a_busy !== 4'h0) begin bad++; $display("FAIL reset_busy_a got=%h exp=0", a_busy); end
      total++;
      if (b_sig !== 1'b0) begin bad++; $display("FAIL reset_sig_b got=%b exp=0", b_sig); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      total++;
      if (a_gcnt !== 8'd0) begin bad++; $display("FAIL reset_gcnt got=%0d exp=0", a_gcnt); end
`endif
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_latency();
      logic [3:0] exp_sig;
      logic [3:0] exp_busy;
      for (int k = 0; k <= 6; k++) begin
         tick();
         exp_sig  = (k >= 5) ? 4'hF : 4'h0;
         exp_busy = (k >= 2 && k <= 4) ? 4'hF : 4'h0;
         total++;
         if (a_sig !== exp_sig) begin bad++; $display("FAIL latency_sig_a edge=%0d got=%h exp=%h", k, a_sig, exp_sig); end
         total++;
         if (a_busy !== exp_busy) begin bad++; $display("FAIL latency_busy_a edge=%0d got=%h exp=%h", k, a_busy, exp_busy); end
         total++;
         if (b_sig !== (k >= 3)) begin bad++; $display("FAIL latency_sig_b edge=%0d got=%b exp=%b", k, b_sig, (k >= 3)); end
         total++;
         if (b_busy !== 1'b0) begin bad++; $display("FAIL latency_busy_b edge=%0d got=%b exp=0", k, b_busy); end
      end
      b_in = 1'b0;
      for (int k = 0; k <= 3; k++) begin
         tick();
         total++;
         if (b_sig !== (k < 3)) begin bad++; $display("FAIL fall_sig_b edge=%0d got=%b exp=%b", k, b_sig, (k < 3)); end
      end
   endtask

   task automatic test_async_reset();
      rst_n = 1'b0;
      #2;
      total++;
      if (a_sig !== 4'h0) begin bad++; $display("FAIL async_reset_sig got=%h exp=0", a_sig); end
      total++;
      if (a_busy !== 4'h0) begin bad++; $display("FAIL async_reset_busy got=%h exp=0", a_busy); end
   endtask

   task automatic test_glitch();
      logic exp_busy;
      apply_reset(4'h0, 1'b0);
      tick(); tick(); tick();
      a_in = 4'b0001;
      for (int k = 0; k <= 9; k++) begin
         tick();
         if (k == 2) a_in = 4'b0000;
         exp_busy = (k >= 2 && k <= 4);
         total++;
         if (a_sig !== 4'h0) begin bad++; $display("FAIL glitch_sig edge=%0d got=%h exp=0", k, a_sig); end
         total++;
         if (a_busy !== {3'b000, exp_busy}) begin bad++; $display("FAIL glitch_busy edge=%0d got=%h exp=%b", k, a_busy, exp_busy); end
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      total++;
      if (a_gcnt !== 8'd1) begin bad++; $display("FAIL glitch_cnt got=%0d exp=1", a_gcnt); end
`endif
   endtask

   task automatic test_bounce();
      int   rises;
      logic prev;
      logic exp_busy;
      apply_reset(4'h0, 1'b0);
      tick(); tick(); tick();
      rises = 0;
      prev  = a_sig[0];
      for (int k = 0; k <= 16; k++) begin
         a_in[0] = (k >= 8) ? 1'b1 : (((k / 2) % 2) == 0);
         tick();
         if (a_sig[0] && !prev) rises++;
         prev = a_sig[0];
         exp_busy = (k == 2 || k == 3 || k == 6 || k == 7 || k == 10 || k == 11 || k == 12);
         total++;
         if (a_sig[0] !== (k >= 13)) begin bad++; $display("FAIL bounce_sig edge=%0d got=%b exp=%b", k, a_sig[0], (k >= 13)); end
         total++;
         if (a_busy[0] !== exp_busy) begin bad++; $display("FAIL bounce_busy edge=%0d got=%b exp=%b", k, a_busy[0], exp_busy); end
      end
      total++;
      if (rises !== 1) begin bad++; $display("FAIL bounce_rises got=%0d exp=1", rises); end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      total++;
      if (a_gcnt !== 8'd2) begin bad++; $display("FAIL bounce_gcnt got=%0d exp=2", a_gcnt); end
`endif
   endtask

   task automatic test_width();
      logic [3:0] exp_sig;
      logic [3:0] exp_busy;
      apply_reset(4'h0, 1'b0);
      tick(); tick();
      a_in = 4'b1101;
      for (int k = 0; k <= 8; k++) begin
         tick();
         if (k == 1) a_in = 4'b0101;
         exp_sig  = (k >= 5) ? 4'b0101 : 4'b0000;
         exp_busy = (k == 2 || k == 3) ? 4'b1101 : ((k == 4) ? 4'b0101 : 4'b0000);
         total++;
         if (a_sig !== exp_sig) begin bad++; $display("FAIL width_sig edge=%0d got=%b exp=%b", k, a_sig, exp_sig); end
         total++;
         if (a_busy !== exp_busy) begin bad++; $display("FAIL width_busy edge=%0d got=%b exp=%b", k, a_busy, exp_busy); end
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      total++;
      if (a_gcnt !== 8'd1) begin bad++; $display("FAIL width_gcnt got=%0d exp=1", a_gcnt); end
`endif
   endtask

   task automatic test_mid_reset();
      apply_reset(4'h0, 1'b0);
      tick(); tick();
      a_in = 4'b0001;
      tick(); tick(); tick();
      total++;
      if (a_busy !== 4'b0001) begin bad++; $display("FAIL mid_busy_before got=%b exp=0001", a_busy); end
      rst_n = 1'b0;
      #2;
      total++;
      if (a_busy !== 4'h0) begin bad++; $display("FAIL mid_busy_reset got=%b exp=0000", a_busy); end
      total++;
      if (a_sig !== 4'h0) begin bad++; $display("FAIL mid_sig_reset got=%b exp=0000", a_sig); end
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         tick();
         total++;
         if (a_sig[0] !== (k >= 5)) begin bad++; $display("FAIL mid_sig edge=%0d got=%b exp=%b", k, a_sig[0], (k >= 5)); end
         total++;
         if (a_busy[0] !== (k >= 2 && k <= 4)) begin bad++; $display("FAIL mid_busy edge=%0d got=%b exp=%b", k, a_busy[0], (k >= 2 && k <= 4)); end
      end
   endtask

   task automatic test_saturation();
`ifdef DEBOUNCE_GLITCH_CNT_EN
      apply_reset(4'h0, 1'b0);
      tick(); tick();
      for (int n = 0; n < 300; n++) begin
         a_in = 4'b0001;
         tick();
         a_in = 4'b0000;
         tick();
         tick();
      end
      tick(); tick(); tick(); tick();
      total++;
      if (a_gcnt !== 8'd255) begin bad++; $display("FAIL sat_gcnt got=%0d exp=255", a_gcnt); end
      total++;
      if (a_sig !== 4'h0) begin bad++; $display("FAIL sat_sig got=%b exp=0000", a_sig); end
`endif
   endtask

   initial begin
      test_reset();
      test_latency();
      test_async_reset();
      test_glitch();
      test_bounce();
      test_width();
      test_mid_reset();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_debouncer.md
Name: sync_debouncer

Overview:
- Input conditioning stage directly upstream of the edge detector.
- Brings asynchronous, bouncy inputs (buttons, external strobes) into the clk domain through a flop synchronizer chain.
- Per bit, filters out any level change that does not hold for STABLE_CYCLES consecutive sampled cycles.
- The clean, registered `signal` output drives the edge detector's `signal` input directly.

Parameters:
- WIDTH, 1: number of independent input bits.
- SYNC_STAGES, 2: synchronizer depth; legal range ≥2.
- STABLE_CYCLES, 4: consecutive mismatching samples required before `signal` changes; legal range ≥1.
- RESET_VAL, 0: reset level for every bit of `signal` and of all synchronizer stages; WIDTH bits.

Ports:
- clk  input  1  system clock; single clock domain.
- n_rst  input  1  asynchronous, active-low reset.
- async_in  input  WIDTH  raw asynchronous inputs.
- signal  output  WIDTH  debounced, synchronized level; feeds edge detector.
- busy  output  WIDTH  per bit, high while a candidate change is being qualified.

Behaviour:
- Interface: one clock, clk. Reset is n_rst: asynchronous, active-low.
- Reset (n_rst=0, asynchronous):
  - all synchronizer stages = RESET_VAL
  - signal = RESET_VAL
  - all counters = 0, busy = 0
  - all bits in STABLE
- Reset release: the first clocked update is on the first posedge clk with n_rst=1.
- Synchronizer: per bit, SYNC_STAGES-deep shift register clocked on posedge clk. `sync_out` is the last stage. No logic between stages.
- Per-bit filter, a two-state FSM with a mismatch counter `cnt`:
  - Counter width is clog2(STABLE_CYCLES+1).
  - The counter never exceeds STABLE_CYCLES and never wraps.
- FSM transitions, evaluated at each posedge clk:
  - STABLE, sync_out == signal: hold; cnt=0.
  - STABLE, sync_out != signal, STABLE_CYCLES==1: toggle signal; stay STABLE; cnt=0.
  - STABLE, sync_out != signal, STABLE_CYCLES>1: go to PENDING; cnt=1.
  - PENDING, sync_out == signal (glitch rejected): go to STABLE; cnt=0; signal unchanged.
  - PENDING, sync_out != signal, cnt+1 < STABLE_CYCLES: cnt=cnt+1.
  - PENDING, sync_out != signal, cnt+1 == STABLE_CYCLES: signal = sync_out; go to STABLE; cnt=0.
- busy[i] = (state[i]==PENDING); registered; no combinational path from async_in.
- Latency:
  - An input level set up before edge 0 and held appears on `signal` after edge SYNC_STAGES+STABLE_CYCLES-1.
  - Defaults: change visible after the 6th edge (edge 5).
- Minimum pulse passed: the level must be held at sync_out for STABLE_CYCLES consecutive samples. Shorter pulses never reach `signal`.
- Signal change rate: `signal` changes at most once per STABLE_CYCLES cycles per bit.
- Bit independence: bits are fully independent; simultaneous changes on several bits are qualified separately and may update `signal` in the same cycle.
- Reset mid-qualification: pending count is discarded; signal returns to RESET_VAL. Downstream edge detector loads `signal` during reset, so no spurious edge is produced.
- Output stability: `signal` is a flop output and glitch-free. It is the only value the edge detector consumes.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- When defined:
  - Adds output port `glitch_cnt`, 8 bits, reset 0.
  - Increments by 1 on each posedge where at least one bit takes the PENDING → STABLE rejection transition.
  - Saturates at 255; never wraps.
  - Cleared only by n_rst.
- When undefined: port, counter and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, defaults, RESET_VAL=0:
  - Assert n_rst while async_in=1 → signal=0, busy=0 immediately (asynchronous, no clk edge needed).
  - Release n_rst, hold async_in=1 → busy rises after edge 2, signal=1 after edge 5, busy=0 after edge 5.
- Glitch rejection: signal=0; async_in=1 for 3 clk cycles then 0 → signal stays 0; busy pulses high then clears. With the macro defined, glitch_cnt=1.
- Bounce train: async_in toggles 1,0,1,0,1 at 2-cycle spacing, then holds 1 → signal rises exactly once, 4 samples after the final stable 1 reaches sync_out. Downstream pos_edge pulses exactly once.
- STABLE_CYCLES=1, SYNC_STAGES=3: async_in 0→1 before edge 0 → signal=1 after edge 3; busy never asserts.
- WIDTH=4: async_in=4'b0101 held, with bit 3 pulsed for 2 cycles → signal=4'b0101 after qualification; bit 3 stays 0.
- Mid-qualification reset: n_rst pulsed low while busy=1 → cnt cleared, signal=RESET_VAL. After release, full SYNC_STAGES+STABLE_CYCLES latency is required again. With the macro defined, glitch_cnt saturates at 255 after 300 rejected glitches.
